// File: rtl/hotcache.sv
// hotcache: small fully-associative cache of recent memory words tagged by (base register, offset).
// Define HOTCACHE_BYPASS_EN to forward a same-cycle fill straight to the lookup port.
module hotcache #(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic [2:0]  rd_reg,
    input  logic [15:0] rd_offset,
    output logic [15:0] rd_data,
    output logic        rd_cached,
    input  logic [2:0]  crb_reg,
    input  logic        crb_commit,
    input  logic        cmd_cache,
    input  logic [2:0]  cmd_reg,
    input  logic [15:0] cmd_offset,
    input  logic [15:0] cmd_data
);

    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [2:0]         reg_q  [ENTRIES];
    logic [2:0]         reg_d  [ENTRIES];
    logic [15:0]        off_q  [ENTRIES];
    logic [15:0]        off_d  [ENTRIES];
    logic [15:0]        data_q [ENTRIES];
    logic [15:0]        data_d [ENTRIES];
    logic [IW-1:0]      victim_q, victim_d;

    logic               hit;
    logic [15:0]        hit_data;
    logic               fwd;
    logic               tag_hit, free_any, fill_drop, do_fill;
    logic [IW-1:0]      tag_idx, free_idx, fill_idx;

    // Lookup: scan high-to-low so the lowest matching index ends up winning.
    always_comb begin
        hit      = 1'b0;
        hit_data = 16'h0000;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && reg_q[i] == rd_reg && off_q[i] == rd_offset) begin
                hit      = 1'b1;
                hit_data = data_q[i];
            end
        end
    end

    assign fill_drop = crb_commit && (cmd_reg == crb_reg);
    assign do_fill   = cmd_cache && !fill_drop;

`ifdef HOTCACHE_BYPASS_EN
    assign fwd = do_fill && (cmd_reg == rd_reg) && (cmd_offset == rd_offset);
`else
    assign fwd = 1'b0;
`endif

    always_comb begin
        rd_cached = 1'b0;
        rd_data   = 16'h0000;
        if (!a_rst) begin
            if (fwd) begin
                rd_cached = 1'b1;
                rd_data   = cmd_data;
            end else if (hit) begin
                rd_cached = 1'b1;
                rd_data   = hit_data;
            end
        end
    end

    // Fill target: existing tag first, then lowest free line, then the round-robin victim.
    always_comb begin
        tag_hit  = 1'b0;
        tag_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && reg_q[i] == cmd_reg && off_q[i] == cmd_offset) begin
                tag_hit = 1'b1;
                tag_idx = IW'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
        if (tag_hit) begin
            fill_idx = tag_idx;
        end else if (free_any) begin
            fill_idx = free_idx;
        end else begin
            fill_idx = victim_q;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        reg_d    = reg_q;
        off_d    = off_q;
        data_d   = data_q;
        victim_d = victim_q;
        if (crb_commit) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (reg_q[i] == crb_reg) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
        // A fill lands after the invalidate so a reused line keeps its new tag.
        if (do_fill) begin
            valid_d[fill_idx] = 1'b1;
            reg_d[fill_idx]   = cmd_reg;
            off_d[fill_idx]   = cmd_offset;
            data_d[fill_idx]  = cmd_data;
            if (!tag_hit && !free_any) begin
                victim_d = victim_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            valid_q  <= '0;
            victim_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                reg_q[i]  <= 3'd0;
                off_q[i]  <= 16'h0000;
                data_q[i] <= 16'h0000;
            end
        end else begin
            valid_q  <= valid_d;
            victim_q <= victim_d;
            for (int i = 0; i < ENTRIES; i++) begin
                reg_q[i]  <= reg_d[i];
                off_q[i]  <= off_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_hotcache.sv
// Bench for hotcache: vector table for basic fill/lookup/invalidate, hand sequences for wrap and mid-run reset.
module tb_hotcache;

  localparam int ENTRIES = 8;
`ifdef HOTCACHE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        a_rst;
  logic [2:0]  rd_reg;
  logic [15:0] rd_offset;
  logic [15:0] rd_data;
  logic        rd_cached;
  logic [2:0]  crb_reg;
  logic        crb_commit;
  logic        cmd_cache;
  logic [2:0]  cmd_reg;
  logic [15:0] cmd_offset;
  logic [15:0] cmd_data;

  hotcache #(.ENTRIES(ENTRIES)) dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .rd_reg     (rd_reg),
    .rd_offset  (rd_offset),
    .rd_data    (rd_data),
    .rd_cached  (rd_cached),
    .crb_reg    (crb_reg),
    .crb_commit (crb_commit),
    .cmd_cache  (cmd_cache),
    .cmd_reg    (cmd_reg),
    .cmd_offset (cmd_offset),
    .cmd_data   (cmd_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  rr;
    logic [15:0] ro;
    logic        cc;
    logic [2:0]  cr;
    logic        fc;
    logic [2:0]  fr;
    logic [15:0] fo;
    logic [15:0] fd;
    logic        ec;
    logic [15:0] ed;
  } vec_t;

  localparam int NV = 18;
  vec_t vt[NV];

  // scoreboard
  logic [16:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic rst, logic [2:0] rr, logic [15:0] ro,
                              logic cc, logic [2:0] cr,
                              logic fc, logic [2:0] fr, logic [15:0] fo, logic [15:0] fd,
                              logic ec, logic [15:0] ed);
    vec_t v;
    v.rst = rst; v.rr = rr; v.ro = ro; v.cc = cc; v.cr = cr;
    v.fc = fc; v.fr = fr; v.fo = fo; v.fd = fd; v.ec = ec; v.ed = ed;
    return v;
  endfunction

  task automatic check_out(input string name);
    logic [16:0] exp_v;
    logic [16:0] act_v;
    act_v = {rd_cached, rd_data};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, got cached=%0b data=%h", name, rd_cached, rd_data);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s: got cached=%0b data=%h, want cached=%0b data=%h",
                 name, act_v[16], act_v[15:0], exp_v[16], exp_v[15:0]);
      end
    end
  endtask

  // driver tasks
  task automatic quiet();
    cmd_cache  = 1'b0;
    crb_commit = 1'b0;
    cmd_reg    = 3'd0;
    cmd_offset = 16'h0000;
    cmd_data   = 16'h0000;
    crb_reg    = 3'd0;
  endtask

  task automatic fill(input logic [2:0] r, input logic [15:0] o, input logic [15:0] d);
    @(negedge clk);
    cmd_cache  = 1'b1;
    cmd_reg    = r;
    cmd_offset = o;
    cmd_data   = d;
    rd_reg     = 3'd7;
    rd_offset  = 16'hFFFF;
    @(posedge clk);
    #1;
    quiet();
  endtask

  task automatic look(input string name, input logic [2:0] r, input logic [15:0] o,
                      input logic ec, input logic [15:0] ed);
    @(negedge clk);
    quiet();
    rd_reg    = r;
    rd_offset = o;
    exp_q.push_back({ec, ed});
    #2;
    check_out(name);
  endtask

  function automatic logic [2:0] wreg(int k);
    return k[2:0];
  endfunction

  function automatic logic [15:0] woff(int k);
    return 16'h0100 + 16'(k);
  endfunction

  initial begin
    a_rst     = 1'b1;
    rd_reg    = 3'd0;
    rd_offset = 16'h0000;
    quiet();

    vt[0]  = mk(1, 3'd2, 16'h0010, 0, 3'd0, 1, 3'd2, 16'h0010, 16'hBEEF, 0, 16'h0000);
    vt[1]  = mk(0, 3'd2, 16'h0010, 0, 3'd0, 0, 3'd0, 16'h0000, 16'h0000, 0, 16'h0000);
    vt[2]  = mk(0, 3'd7, 16'h0000, 0, 3'd0, 1, 3'd2, 16'h0010, 16'hBEEF, 0, 16'h0000);
    vt[3]  = mk(0, 3'd2, 16'h0010, 0, 3'd0, 0, 3'd0, 16'h0000, 16'h0000, 1, 16'hBEEF);
    vt[4]  = mk(0, 3'd2, 16'h0011, 0, 3'd0, 0, 3'd0, 16'h0000, 16'h0000, 0, 16'h0000);
    vt[5]  = mk(0, 3'd3, 16'h0010, 0, 3'd0, 1, 3'd2, 16'h0010, 16'h1234, 0, 16'h0000);
    vt[6]  = mk(0, 3'd2, 16'h0010, 0, 3'd0, 1, 3'd1, 16'h0004, 16'hAAAA, 1, 16'h1234);
    vt[7]  = mk(0, 3'd1, 16'h0004, 0, 3'd0, 1, 3'd5, 16'h0004, 16'h5555, 1, 16'hAAAA);
    vt[8]  = mk(0, 3'd5, 16'h0004, 1, 3'd1, 0, 3'd0, 16'h0000, 16'h0000, 1, 16'h5555);
    vt[9]  = mk(0, 3'd1, 16'h0004, 0, 3'd0, 0, 3'd0, 16'h0000, 16'h0000, 0, 16'h0000);
    vt[10] = mk(0, 3'd4, 16'h0000, 1, 3'd4, 1, 3'd4, 16'h0000, 16'hCAFE, 0, 16'h0000);
    vt[11] = mk(0, 3'd4, 16'h0000, 0, 3'd0, 0, 3'd0, 16'h0000, 16'h0000, 0, 16'h0000);
    vt[12] = mk(0, 3'd5, 16'h0004, 1, 3'd5, 1, 3'd6, 16'h0001, 16'h1111, 1, 16'h5555);
    vt[13] = mk(0, 3'd5, 16'h0004, 0, 3'd0, 0, 3'd0, 16'h0000, 16'h0000, 0, 16'h0000);
    vt[14] = mk(0, 3'd6, 16'h0001, 0, 3'd0, 0, 3'd0, 16'h0000, 16'h0000, 1, 16'h1111);
    vt[15] = mk(0, 3'd3, 16'h0003, 0, 3'd0, 1, 3'd3, 16'h0003, 16'h3333, BYP, BYP ? 16'h3333 : 16'h0000);
    vt[16] = mk(0, 3'd3, 16'h0003, 0, 3'd0, 0, 3'd0, 16'h0000, 16'h0000, 1, 16'h3333);
    vt[17] = mk(0, 3'd2, 16'h0010, 0, 3'd0, 0, 3'd0, 16'h0000, 16'h0000, 1, 16'h1234);

    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_rst      = vt[i].rst;
      rd_reg     = vt[i].rr;
      rd_offset  = vt[i].ro;
      crb_commit = vt[i].cc;
      crb_reg    = vt[i].cr;
      cmd_cache  = vt[i].fc;
      cmd_reg    = vt[i].fr;
      cmd_offset = vt[i].fo;
      cmd_data   = vt[i].fd;
      exp_q.push_back({vt[i].ec, vt[i].ed});
      #2;
      check_out($sformatf("vec%0d", i));
    end
    @(negedge clk);
    quiet();

    // Wrap: a refill of tag0 must not consume a second line.
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    fill(wreg(0), woff(0), 16'hD000);
    fill(wreg(0), woff(0), 16'h0ABC);
    for (int k = 1; k < ENTRIES; k++) fill(wreg(k), woff(k), 16'hD000 + 16'(k));
    look("full_tag0", wreg(0), woff(0), 1'b1, 16'h0ABC);
    for (int k = 1; k < ENTRIES; k++)
      look($sformatf("full_tag%0d", k), wreg(k), woff(k), 1'b1, 16'hD000 + 16'(k));

    fill(wreg(ENTRIES), woff(ENTRIES), 16'hD000 + 16'(ENTRIES));
    look("evict_tag0", wreg(0), woff(0), 1'b0, 16'h0000);
    look("new_tag8", wreg(ENTRIES), woff(ENTRIES), 1'b1, 16'hD000 + 16'(ENTRIES));
    look("keep_tag1", wreg(1), woff(1), 1'b1, 16'hD001);

    // victim should now be 1: next new tag evicts tag1 only.
    fill(wreg(ENTRIES + 1), woff(ENTRIES + 1), 16'hD000 + 16'(ENTRIES + 1));
    look("evict_tag1", wreg(1), woff(1), 1'b0, 16'h0000);
    look("keep_tag2", wreg(2), woff(2), 1'b1, 16'hD002);
    look("new_tag9", wreg(ENTRIES + 1), woff(ENTRIES + 1), 1'b1, 16'hD000 + 16'(ENTRIES + 1));

    // Asynchronous reset mid-cycle clears lines without a clock edge.
    @(negedge clk);
    quiet();
    rd_reg    = wreg(2);
    rd_offset = woff(2);
    #1;
    a_rst = 1'b1;
    exp_q.push_back({1'b0, 16'h0000});
    #1;
    check_out("async_rst");
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    look("post_rst_tag2", wreg(2), woff(2), 1'b0, 16'h0000);
    look("post_rst_tag9", wreg(ENTRIES + 1), woff(ENTRIES + 1), 1'b0, 16'h0000);

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d expected entries never compared", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
